// File: rtl/pc_rd_req_arbiter.sv
// Round-robin sharing of one AXI4 read port between REQ_NB requesters, with
// ARID-tagged routing of R beats, per-requester outstanding limits and a drain handshake.
module pc_rd_req_arbiter #(
    parameter int REQ_NB     = 4,
    parameter int AXI_ADD_W  = 64,
    parameter int AXI_DATA_W = 512,
    parameter int AXI_ID_W   = 4,
    parameter int OUTST_MAX  = 16
) (
    input  logic                          clk,
    input  logic                          s_rst_n,
    input  logic [REQ_NB-1:0]             req_arvalid,
    output logic [REQ_NB-1:0]             req_arready,
    input  logic [REQ_NB*AXI_ADD_W-1:0]   req_araddr,
    input  logic [REQ_NB*8-1:0]           req_arlen,
    output logic [REQ_NB-1:0]             req_rvalid,
    input  logic [REQ_NB-1:0]             req_rready,
    output logic [AXI_DATA_W-1:0]         req_rdata,
    output logic                          req_rlast,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    output logic [AXI_ADD_W-1:0]          m_axi_araddr,
    output logic [7:0]                    m_axi_arlen,
    output logic [AXI_ID_W-1:0]           m_axi_arid,
    output logic [2:0]                    m_axi_arsize,
    output logic [1:0]                    m_axi_arburst,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready,
    input  logic [AXI_DATA_W-1:0]         m_axi_rdata,
    input  logic                          m_axi_rlast,
    input  logic [AXI_ID_W-1:0]           m_axi_rid,
    input  logic                          drain,
    output logic                          drain_done,
    output logic                          err_rid
);
    localparam int IDX_W = $clog2(REQ_NB);
    localparam int CNT_W = $clog2(OUTST_MAX + 1);
    localparam logic [2:0] AR_SIZE = 3'($clog2(AXI_DATA_W / 8));

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_IDLE} state_e;

    state_e               state;
    logic [IDX_W-1:0]     ptr;
    logic [CNT_W-1:0]     cnt     [REQ_NB];
    logic [CNT_W-1:0]     cnt_nxt [REQ_NB];
    logic                 grant_vld;
    logic [IDX_W-1:0]     grant_idx;
    logic [AXI_ADD_W-1:0] grant_addr;
    logic [7:0]           grant_len;
    logic                 ar_hs, ar_free, ar_full_nxt;
    logic                 r_hs, rid_ok, underflow, cnt_zero_nxt;
    logic [IDX_W-1:0]     rid_idx;

    assign m_axi_arsize  = AR_SIZE;
    assign m_axi_arburst = 2'b01;
    assign ar_hs         = m_axi_arvalid && m_axi_arready;
    assign ar_free       = !m_axi_arvalid || m_axi_arready;
    assign ar_full_nxt   = grant_vld || (m_axi_arvalid && !m_axi_arready);
    assign rid_ok        = ({1'b0, m_axi_rid} < (AXI_ID_W + 1)'(REQ_NB));
    assign rid_idx       = m_axi_rid[IDX_W-1:0];
    assign r_hs          = m_axi_rvalid && m_axi_rready;

    // The burst sitting in the AR register counts against its owner, so a
    // requester at OUTST_MAX-1 cannot be granted twice before its count moves.
    always_comb begin : arbiter
        logic [IDX_W-1:0] idx;
        logic [CNT_W:0]   eff;
        logic             pend;
        grant_vld  = 1'b0;
        grant_idx  = '0;
        grant_addr = '0;
        grant_len  = '0;
        idx        = '0;
        eff        = '0;
        pend       = 1'b0;
        if (s_rst_n && state == ST_RUN && ar_free) begin
            for (int k = REQ_NB - 1; k >= 0; k--) begin
                idx  = ptr + IDX_W'(k);
                pend = m_axi_arvalid && (m_axi_arid == AXI_ID_W'(idx));
                eff  = {1'b0, cnt[idx]} + (CNT_W + 1)'(pend);
                if (req_arvalid[idx] && eff < (CNT_W + 1)'(OUTST_MAX)) begin
                    grant_vld  = 1'b1;
                    grant_idx  = idx;
                    grant_addr = req_araddr[int'(idx)*AXI_ADD_W +: AXI_ADD_W];
                    grant_len  = req_arlen[int'(idx)*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        req_arready = '0;
        if (grant_vld) req_arready[grant_idx] = 1'b1;
    end

    always_comb begin
        cnt_zero_nxt = 1'b1;
        underflow    = r_hs && m_axi_rlast && rid_ok && (cnt[rid_idx] == '0);
        for (int i = 0; i < REQ_NB; i++) begin
            cnt_nxt[i] = cnt[i];
            if (ar_hs && m_axi_arid == AXI_ID_W'(i))
                cnt_nxt[i] = cnt_nxt[i] + CNT_W'(1);
            if (r_hs && m_axi_rlast && rid_ok && rid_idx == IDX_W'(i) && cnt[i] != '0)
                cnt_nxt[i] = cnt_nxt[i] - CNT_W'(1);
            if (cnt_nxt[i] != '0) cnt_zero_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            m_axi_arvalid <= 1'b0;
            ptr           <= '0;
            state         <= ST_RUN;
            drain_done    <= 1'b0;
            err_rid       <= 1'b0;
            for (int i = 0; i < REQ_NB; i++) cnt[i] <= '0;
        end else begin
            if (grant_vld) begin
                m_axi_arvalid <= 1'b1;
                ptr           <= grant_idx + IDX_W'(1);
            end else if (m_axi_arready) begin
                m_axi_arvalid <= 1'b0;
            end
            for (int i = 0; i < REQ_NB; i++) cnt[i] <= cnt_nxt[i];
            if (underflow || (m_axi_rvalid && !rid_ok)) err_rid <= 1'b1;
            case (state)
                ST_RUN: if (drain) state <= ST_DRAIN;
                ST_DRAIN: begin
                    if (!drain) begin
                        state <= ST_RUN;
                    end else if (!ar_full_nxt && cnt_zero_nxt) begin
                        state      <= ST_IDLE;
                        drain_done <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (!drain) begin
                        state      <= ST_RUN;
                        drain_done <= 1'b0;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (grant_vld) begin
            m_axi_araddr <= grant_addr;
            m_axi_arlen  <= grant_len;
            m_axi_arid   <= AXI_ID_W'(grant_idx);
        end
    end

    // R path is pure steering: no storage, backpressure passes straight through.
    assign req_rdata    = m_axi_rdata;
    assign req_rlast    = m_axi_rlast;
    assign m_axi_rready = rid_ok ? req_rready[rid_idx] : 1'b1;

    always_comb begin
        req_rvalid = '0;
        if (m_axi_rvalid && rid_ok) req_rvalid[rid_idx] = 1'b1;
    end
endmodule

// File: tb/tb_pc_rd_req_arbiter.sv
// Randomized bench for pc_rd_req_arbiter: a transaction-level model predicts grants,
// routing and drain status; a separate monitor checks issued AR commands from a queue.
module tb_pc_rd_req_arbiter;
    localparam int N    = 4;
    localparam int AW   = 64;
    localparam int DW   = 512;
    localparam int IW   = 4;
    localparam int OMAX = 16;

    typedef struct { int id; logic [AW-1:0] addr; logic [7:0] len; } ar_t;

    logic            clk = 1'b0;
    logic            s_rst_n;
    logic [N-1:0]    req_arvalid_b, req_arready, req_rvalid, req_rready_b;
    logic [N*AW-1:0] req_araddr;
    logic [N*8-1:0]  req_arlen;
    logic [DW-1:0]   req_rdata, m_rdata_b;
    logic            req_rlast;
    logic            m_axi_arvalid, m_arready_b;
    logic [AW-1:0]   m_axi_araddr;
    logic [7:0]      m_axi_arlen;
    logic [IW-1:0]   m_axi_arid, m_rid_b;
    logic [2:0]      m_axi_arsize;
    logic [1:0]      m_axi_arburst;
    logic            m_rvalid_b, m_axi_rready, m_rlast_b;
    logic            drain_b, drain_done, err_rid;

    logic [AW-1:0]   rq_addr [N];
    logic [7:0]      rq_len  [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign req_araddr[gi*AW +: AW] = rq_addr[gi];
        assign req_arlen[gi*8 +: 8]    = rq_len[gi];
    end

    pc_rd_req_arbiter #(.REQ_NB(N), .AXI_ADD_W(AW), .AXI_DATA_W(DW),
                        .AXI_ID_W(IW), .OUTST_MAX(OMAX)) dut (
        .clk(clk), .s_rst_n(s_rst_n),
        .req_arvalid(req_arvalid_b), .req_arready(req_arready),
        .req_araddr(req_araddr), .req_arlen(req_arlen),
        .req_rvalid(req_rvalid), .req_rready(req_rready_b),
        .req_rdata(req_rdata), .req_rlast(req_rlast),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_arready_b),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arid(m_axi_arid),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_rvalid(m_rvalid_b), .m_axi_rready(m_axi_rready),
        .m_axi_rdata(m_rdata_b), .m_axi_rlast(m_rlast_b), .m_axi_rid(m_rid_b),
        .drain(drain_b), .drain_done(drain_done), .err_rid(err_rid)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // stimulus knobs
    logic [N-1:0] req_en;
    int new_prob, r_prob, rr_prob, ar_mode;
    bit r_en, slave_on;

    // observations the stimulus reacts to (captured at negedge)
    logic [N-1:0] gnt_seen;
    bit r_acc;
    int sb_id[$], sb_len[$];
    int beat = 0, beats0 = 0;

    // reference model state
    typedef enum {M_RUN, M_DRAIN, M_IDLE} mst_e;
    mst_e st_m;
    int   ptr_m, reg_id_m;
    int   cnt_m [N];
    bit   reg_full_m, err_m;
    ar_t  exp_ar[$];

    always @(negedge clk) begin
        if (!s_rst_n) begin
            gnt_seen = '0;
            r_acc    = 1'b0;
        end else begin
            gnt_seen = req_arready & req_arvalid_b;
            r_acc    = m_rvalid_b && m_axi_rready;
            if (m_axi_arvalid && m_arready_b) begin
                sb_id.push_back(int'(m_axi_arid));
                sb_len.push_back(int'(m_axi_arlen));
            end
            if (slave_on && r_acc && sb_id.size() > 0) begin
                if (m_rlast_b) begin
                    void'(sb_id.pop_front());
                    void'(sb_len.pop_front());
                    beat = 0;
                end else beat++;
            end
            if (req_rvalid[0] && req_rready_b[0]) beats0++;
        end
    end

    // Reference model: grants, routing, counters and drain status from the rules.
    always @(negedge clk) begin
        if (!s_rst_n) begin
            chk("rst_arvalid", 64'(m_axi_arvalid), 0);
            chk("rst_req_arready", 64'(req_arready), 0);
            chk("rst_drain_done", 64'(drain_done), 0);
            chk("rst_err_rid", 64'(err_rid), 0);
            st_m = M_RUN; ptr_m = 0; reg_full_m = 0; reg_id_m = 0; err_m = 0;
            for (int i = 0; i < N; i++) cnt_m[i] = 0;
            exp_ar.delete();
        end else begin
            int g, rid_i, eff;
            logic [N-1:0] exp_rdy, exp_rv;
            bit exp_rready, all_zero;
            g = -1;
            if (st_m == M_RUN && (!reg_full_m || m_arready_b))
                for (int k = 0; k < N; k++) begin
                    int id;
                    id  = (ptr_m + k) % N;
                    eff = cnt_m[id] + ((reg_full_m && reg_id_m == id) ? 1 : 0);
                    if (g < 0 && req_arvalid_b[id] && eff < OMAX) g = id;
                end
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("req_arready", 64'(req_arready), 64'(exp_rdy));
            chk("m_arvalid", 64'(m_axi_arvalid), 64'(reg_full_m));
            rid_i       = int'(m_rid_b);
            exp_rready  = (rid_i < N) ? req_rready_b[rid_i] : 1'b1;
            exp_rv      = '0;
            if (m_rvalid_b && rid_i < N) exp_rv[rid_i] = 1'b1;
            chk("m_rready", 64'(m_axi_rready), 64'(exp_rready));
            chk("req_rvalid", 64'(req_rvalid), 64'(exp_rv));
            if (m_rvalid_b) begin
                chk("rdata", 64'(req_rdata == m_rdata_b), 1);
                chk("rlast", 64'(req_rlast), 64'(m_rlast_b));
            end
            chk("drain_done", 64'(drain_done), 64'(st_m == M_IDLE));
            chk("err_rid", 64'(err_rid), 64'(err_m));
            // R completion first, so a return against an empty count is an error.
            if (m_rvalid_b && exp_rready) begin
                if (rid_i >= N) err_m = 1;
                else if (m_rlast_b) begin
                    if (cnt_m[rid_i] == 0) err_m = 1;
                    else cnt_m[rid_i]--;
                end
            end
            if (reg_full_m && m_arready_b) begin
                cnt_m[reg_id_m]++;
                reg_full_m = 0;
            end
            if (g >= 0) begin
                exp_ar.push_back('{g, rq_addr[g], rq_len[g]});
                reg_full_m = 1; reg_id_m = g; ptr_m = (g + 1) % N;
            end
            all_zero = 1;
            for (int i = 0; i < N; i++) if (cnt_m[i] != 0) all_zero = 0;
            case (st_m)
                M_RUN:   if (drain_b) st_m = M_DRAIN;
                M_DRAIN: if (!drain_b) st_m = M_RUN;
                         else if (!reg_full_m && all_zero) st_m = M_IDLE;
                default: if (!drain_b) st_m = M_RUN;
            endcase
        end
    end

    // AR monitor: whatever the port presents must match the oldest predicted grant.
    always @(negedge clk) begin
        if (s_rst_n && m_axi_arvalid) begin
            if (exp_ar.size() == 0) begin
                n_chk++;
                $display("FAIL ar_unexpected: got arid %0d, expected no command", m_axi_arid);
            end else begin
                chk("arid", 64'(m_axi_arid), 64'(exp_ar[0].id));
                chk("araddr", m_axi_araddr, exp_ar[0].addr);
                chk("arlen", 64'(m_axi_arlen), 64'(exp_ar[0].len));
                if (m_arready_b) void'(exp_ar.pop_front());
            end
        end
    end

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (req_arvalid_b[i] && gnt_seen[i]) req_arvalid_b[i] = 1'b0;
            if (!req_arvalid_b[i] && req_en[i] && $urandom_range(99) < new_prob) begin
                req_arvalid_b[i] = 1'b1;
                rq_addr[i]       = {$urandom, $urandom & 32'hFFFF_FFC0};
                rq_len[i]        = 8'($urandom_range(3));
            end
            req_rready_b[i] = ($urandom_range(99) < rr_prob);
        end
        case (ar_mode)
            1:       m_arready_b = 1'b1;
            2:       m_arready_b = 1'b0;
            default: m_arready_b = ($urandom_range(3) != 0);
        endcase
        if ($urandom_range(149) == 0 && ar_mode == 0) drain_b = ~drain_b;
        if (slave_on && !(m_rvalid_b && !r_acc)) begin
            m_rvalid_b = 1'b0;
            m_rlast_b  = 1'b0;
            if (r_en && sb_id.size() > 0 && $urandom_range(99) < r_prob) begin
                m_rvalid_b = 1'b1;
                m_rid_b    = IW'(sb_id[0]);
                m_rlast_b  = (beat == sb_len[0]);
                for (int j = 0; j < DW / 32; j++) m_rdata_b[j*32 +: 32] = $urandom;
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            drive();
        end
    endtask

    initial begin
        int cyc;
        s_rst_n = 1'b0; drain_b = 1'b0;
        req_arvalid_b = '1; req_rready_b = '1; req_en = '0;
        for (int i = 0; i < N; i++) begin rq_addr[i] = 64'(i * 64); rq_len[i] = 8'd0; end
        m_arready_b = 1'b1; m_rvalid_b = 1'b0; m_rlast_b = 1'b0; m_rid_b = '0; m_rdata_b = '0;
        new_prob = 0; r_prob = 100; rr_prob = 100; ar_mode = 1; r_en = 1; slave_on = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("arsize", 64'(m_axi_arsize), 6);
        chk("arburst", 64'(m_axi_arburst), 1);
        // single requester 0, 8-beat burst at 0x1000
        req_arvalid_b = 4'b0001; rq_addr[0] = 64'h1000; rq_len[0] = 8'd7;
        beats0 = 0;
        s_rst_n = 1'b1;
        step(30);
        chk("single_beats0", 64'(beats0), 8);
        // all requesters continuously, sink always ready
        req_en = '1; new_prob = 100;
        step(40);
        // AR sink stalled for 5 cycles
        ar_mode = 2; step(5); ar_mode = 1; step(10);
        // no R returned: every requester saturates at OMAX, then drains
        r_en = 0; step(100); r_en = 1; step(200);
        // drain with bursts outstanding
        r_en = 0; step(10);
        drain_b = 1'b1; step(10);
        r_en = 1;
        cyc = 0;
        while (!drain_done && cyc < 600) begin step(1); cyc++; end
        chk("drain_done_reached", 64'(drain_done), 1);
        step(3);
        drain_b = 1'b0; step(20);
        // fully random traffic with occasional drain toggles
        ar_mode = 0; new_prob = 40; r_prob = 70; rr_prob = 70;
        step(1500);
        // quiesce, then inject a beat with an out-of-range ID
        ar_mode = 1; drain_b = 1'b0; req_en = '0; r_prob = 100; rr_prob = 100;
        cyc = 0;
        while ((sb_id.size() != 0 || m_rvalid_b || exp_ar.size() != 0 || req_arvalid_b != '0)
               && cyc < 3000) begin step(1); cyc++; end
        chk("quiesce_done", 64'(cyc < 3000), 1);
        chk("err_rid_before_bad", 64'(err_rid), 0);
        slave_on = 0;
        @(posedge clk); #1;
        m_rvalid_b = 1'b1; m_rid_b = 4'd5; m_rlast_b = 1'b1;
        @(posedge clk); #1;
        m_rvalid_b = 1'b0; m_rlast_b = 1'b0; m_rid_b = '0;
        step(5);
        chk("err_rid_sticky", 64'(err_rid), 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
